// File: rtl/mem_pkg.sv
// Shared definitions for the SRAM-backed data memory: responder FSM states
// and the byte address at which the data memory window starts.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [31:0] DATA_MEM_BASE = 32'd1024;

endpackage

// File: rtl/sram_mem_responder.sv
// MEM-stage responder that serves 32-bit loads/stores from a 16-bit async SRAM
// as two half-word phases (low half first), stalling the pipeline via ready.
module sram_mem_responder
    import mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = DATA_MEM_BASE,
    parameter int unsigned WAIT_CYCLES = 1,
    parameter int unsigned SRAM_AW     = 18
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [31:0]        address,
    input  logic [31:0]        write_data,
    output logic [31:0]        read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [15:0]        sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [15:0]        sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES);

    state_t             state_q, state_d;
    logic [3:0]         cnt_q, cnt_d;
    logic               wr_q, wr_d;
    logic [31:0]        addr_q, addr_d;
    logic [31:0]        wdata_q, wdata_d;
    logic [31:0]        rdata_q, rdata_d;
    logic [SRAM_AW-1:0] sram_addr_q, sram_addr_d;
    logic [15:0]        dq_out_q, dq_out_d;
    logic               dq_oe_q, dq_oe_d;
    logic               we_n_q, we_n_d;
    logic               oe_n_q, oe_n_d;

    logic               req;
    logic               phase_end;
    logic               phase;
    logic [31:0]        word_off;
    logic               unused_word_bits;

    assign req       = rd_en | wr_en;
    assign phase_end = (cnt_q == WAIT_LAST);
    assign ready     = ~req | (state_q == DONE);

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        wr_d     = wr_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        rdata_d  = rdata_q;

        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = LOW;
                    cnt_d   = 4'd0;
                    wr_d    = wr_en;
                    addr_d  = address;
                    wdata_d = write_data;
                end
            end
            LOW: begin
                if (phase_end) begin
                    state_d = HIGH;
                    cnt_d   = 4'd0;
                    if (!wr_q) rdata_d[15:0] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            HIGH: begin
                if (phase_end) begin
                    state_d = DONE;
                    cnt_d   = 4'd0;
                    if (!wr_q) rdata_d[31:16] = sram_dq_in;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Strobes are computed for the state being entered so they are registered
    // yet line up exactly with the LOW/HIGH cycles; addr_d/wdata_d/wr_d already
    // select the incoming request on acceptance and the latched copy afterwards.
    always_comb begin
        phase       = (state_d == HIGH);
        word_off    = addr_d - BASE_ADDR;
        sram_addr_d = sram_addr_q;
        dq_out_d    = dq_out_q;
        dq_oe_d     = 1'b0;
        we_n_d      = 1'b1;
        oe_n_d      = 1'b1;
        if (state_d == LOW || state_d == HIGH) begin
            sram_addr_d = {word_off[SRAM_AW:2], phase};
            if (wr_d) begin
                dq_oe_d  = 1'b1;
                we_n_d   = 1'b0;
                dq_out_d = phase ? wdata_d[31:16] : wdata_d[15:0];
            end else begin
                oe_n_d = 1'b0;
            end
        end
    end

    assign unused_word_bits = ^{word_off[31:SRAM_AW+1], word_off[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            wr_q        <= 1'b0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            rdata_q     <= 32'd0;
            sram_addr_q <= '0;
            dq_out_q    <= 16'd0;
            dq_oe_q     <= 1'b0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wr_q        <= wr_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            sram_addr_q <= sram_addr_d;
            dq_out_q    <= dq_out_d;
            dq_oe_q     <= dq_oe_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
        end
    end

    assign read_data   = rdata_q;
    assign sram_addr   = sram_addr_q;
    assign sram_dq_out = dq_out_q;
    assign sram_dq_oe  = dq_oe_q;
    assign sram_we_n   = we_n_q;
    assign sram_oe_n   = oe_n_q;

endmodule

// File: tb/tb_sram_mem_responder.sv
// Directed bench for sram_mem_responder with WAIT_CYCLES=1 against a simple
// behavioural 16-bit SRAM array.
module tb_sram_mem_responder;
    import mem_pkg::*;

    localparam int AW = 18;

    logic          clk;
    logic          reset;
    logic          rd_en;
    logic          wr_en;
    logic [31:0]   address;
    logic [31:0]   write_data;
    logic [31:0]   read_data;
    logic          ready;
    logic [AW-1:0] sram_addr;
    logic [15:0]   sram_dq_out;
    logic          sram_dq_oe;
    logic [15:0]   sram_dq_in;
    logic          sram_we_n;
    logic          sram_oe_n;

    int total = 0;
    int bad   = 0;

    logic [15:0] sram_mem [0:(1<<AW)-1];

    sram_mem_responder #(
        .BASE_ADDR  (DATA_MEM_BASE),
        .WAIT_CYCLES(1),
        .SRAM_AW    (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .rd_en      (rd_en),
        .wr_en      (wr_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural SRAM: combinational read while oe_n is low, write while we_n is low.
    assign sram_dq_in = sram_oe_n ? 16'h0000 : sram_mem[sram_addr];
    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drives the request (cycle 0), checks every cycle up
    // to DONE (cycle 5), switches the address to a_mid after acceptance, then
    // drops the request.
    task automatic access(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] a_mid, input logic [31:0] d,
                          input logic [AW-1:0] exp_base, input logic [31:0] exp_rd);
        logic ph;
        rd_en = r; wr_en = w; address = a; write_data = d;
        #1;
        chk("ready_c0", {31'd0, ready}, 32'd0);
        for (int c = 1; c <= 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            ph = (c >= 3);
            chk($sformatf("ready_c%0d", c), {31'd0, ready}, (c == 5) ? 32'd1 : 32'd0);
            if (c <= 4) begin
                chk($sformatf("addr_c%0d", c), 32'(sram_addr), 32'(exp_base) + 32'(ph));
                if (w) begin
                    chk($sformatf("we_n_c%0d", c), {31'd0, sram_we_n}, 32'd0);
                    chk($sformatf("dq_oe_c%0d", c), {31'd0, sram_dq_oe}, 32'd1);
                    chk($sformatf("dq_c%0d", c), {16'd0, sram_dq_out}, ph ? {16'd0, d[31:16]} : {16'd0, d[15:0]});
                end else begin
                    chk($sformatf("oe_n_c%0d", c), {31'd0, sram_oe_n}, 32'd0);
                    chk($sformatf("rd_we_n_c%0d", c), {31'd0, sram_we_n}, 32'd1);
                end
            end else begin
                chk("done_we_n", {31'd0, sram_we_n}, 32'd1);
                chk("done_oe_n", {31'd0, sram_oe_n}, 32'd1);
                chk("done_rdata", read_data, exp_rd);
            end
            if (c == 1) address = a_mid;
        end
        rd_en = 1'b0; wr_en = 1'b0;
        @(posedge clk);
        @(negedge clk);
        chk("idle_ready", {31'd0, ready}, 32'd1);
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) sram_mem[i] = 16'h0000;
        reset = 1'b1; rd_en = 1'b0; wr_en = 1'b0; address = 32'd0; write_data = 32'd0;
        repeat (2) @(negedge clk);
        chk("rst_ready", {31'd0, ready}, 32'd1);
        chk("rst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("rst_oe_n", {31'd0, sram_oe_n}, 32'd1);
        chk("rst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("rst_rdata", read_data, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, ready}, 32'd1);

        access(1'b0, 1'b1, 32'd1024, 32'd1024, 32'hDEADBEEF, 18'd0, 32'd0);
        chk("mem0", {16'd0, sram_mem[0]}, 32'h0000BEEF);
        chk("mem1", {16'd0, sram_mem[1]}, 32'h0000DEAD);
        access(1'b1, 1'b0, 32'd1024, 32'd1024, 32'd0, 18'd0, 32'hDEADBEEF);

        access(1'b0, 1'b1, 32'd1028, 32'd1028, 32'h12345678, 18'd2, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'd1028, 32'd1028, 32'd0, 18'd2, 32'h12345678);
        access(1'b1, 1'b0, 32'd1024, 32'd1024, 32'd0, 18'd0, 32'hDEADBEEF);
        access(1'b1, 1'b0, 32'd1028, 32'd1028, 32'd0, 18'd2, 32'h12345678);

        // Both enables high means write; address moves mid-request.
        access(1'b1, 1'b1, 32'd1032, 32'd1040, 32'hA5A50F0F, 18'd4, 32'h12345678);
        chk("mem4", {16'd0, sram_mem[4]}, 32'h00000F0F);
        chk("mem5", {16'd0, sram_mem[5]}, 32'h0000A5A5);
        chk("mem8_untouched", {16'd0, sram_mem[8]}, 32'h00000000);
        access(1'b1, 1'b0, 32'd1032, 32'd1032, 32'd0, 18'd4, 32'hA5A50F0F);

        // Reset during the HIGH phase of a write.
        wr_en = 1'b1; address = 32'd1036; write_data = 32'h11112222;
        repeat (3) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("pre_rst_we_n", {31'd0, sram_we_n}, 32'd0);
        chk("pre_rst_addr", 32'(sram_addr), 32'd7);
        reset = 1'b1;
        #1;
        chk("midrst_we_n", {31'd0, sram_we_n}, 32'd1);
        chk("midrst_dq_oe", {31'd0, sram_dq_oe}, 32'd0);
        chk("midrst_rdata", read_data, 32'd0);
        chk("midrst_ready_held", {31'd0, ready}, 32'd0);
        wr_en = 1'b0;
        #1;
        chk("midrst_ready_idle", {31'd0, ready}, 32'd1);
        wr_en = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        access(1'b0, 1'b1, 32'd1036, 32'd1036, 32'h11112222, 18'd6, 32'd0);
        access(1'b1, 1'b0, 32'd1036, 32'd1036, 32'd0, 18'd6, 32'h11112222);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sram_mem_responder.md
Name: sram_mem_responder

Overview:
- Memory-side responder to the pipeline's MEM-stage read/write requests. Replaces the single-cycle data memory with an external 16-bit asynchronous SRAM.
- Each 32-bit access is split into two half-word SRAM phases, with configurable wait states per phase.
- Holds `ready` low while busy; the top level freezes the pipeline on `ready`=0.

Parameters:
- BASE_ADDR, 1024, byte address that maps to SRAM half-word 0.
- WAIT_CYCLES, 1, extra cycles per half-word phase. Each phase lasts WAIT_CYCLES+1 cycles. Legal range 0..15.
- SRAM_AW, 18, SRAM half-word address width.

Ports:
- clk  in  1  pipeline clock
- reset  in  1  asynchronous, active-high
- rd_en  in  1  MEM-stage read request; held while `ready`=0
- wr_en  in  1  MEM-stage write request; held while `ready`=0
- address  in  32  byte address (ALU result)
- write_data  in  32  store data (Val_Rm)
- read_data  out  32  load data
- ready  out  1  request complete / responder idle
- sram_addr  out  SRAM_AW  SRAM half-word address
- sram_dq_out  out  16  write data to SRAM
- sram_dq_oe  out  1  tristate enable for sram_dq_out; driven at the pad by the top level
- sram_dq_in  in  16  read data from SRAM
- sram_we_n  out  1  SRAM write enable, active-low
- sram_oe_n  out  1  SRAM output enable, active-low

Behaviour:
- Reset values (asynchronous): state=IDLE, read_data=0, sram_addr=0, sram_dq_out=0, sram_dq_oe=0, sram_we_n=1, sram_oe_n=1, wait counter=0.
- `ready` is combinational: ready = ~(rd_en|wr_en) | (state==DONE). With no request it reads 1, including directly after reset.
- FSM states: IDLE, LOW, HIGH, DONE.
  - IDLE: if rd_en|wr_en, latch op, address and write_data into internal registers; go to LOW.
  - If rd_en and wr_en are both high, the access is a write.
  - LOW, HIGH: counter runs 0..WAIT_CYCLES. LOW→HIGH and HIGH→DONE occur when counter==WAIT_CYCLES.
  - DONE: one cycle with `ready`=1; the pipeline advances at this edge. DONE→IDLE unconditionally.
  - A held request therefore never retriggers.
  - A new request is accepted only from IDLE, at the earliest the cycle after DONE.
- Address map: word = (addr_latched - BASE_ADDR) >> 2, using 32-bit modulo subtraction.
  - sram_addr = {word[SRAM_AW-2:0], phase}, where phase=0 in LOW and phase=1 in HIGH.
  - Upper word bits and address[1:0] are ignored.
- Little-endian split:
  - LOW carries data[15:0].
  - HIGH carries data[31:16].
- Write phases:
  - sram_dq_oe=1, sram_we_n=0 and sram_oe_n=1 for every cycle of the phase.
  - sram_dq_out holds the selected half of the latched data.
- Read phases:
  - sram_dq_oe=0, sram_we_n=1, sram_oe_n=0.
  - sram_dq_in is captured on the last cycle of the phase: LOW loads read_data[15:0], HIGH loads read_data[31:16].
- read_data holds its value until the next read overwrites it. Writes do not change it.
- Outside LOW/HIGH: sram_we_n=1, sram_oe_n=1, sram_dq_oe=0.
- Latency:
  - Request first seen in cycle 0. DONE (`ready`=1) occurs in cycle 2*(WAIT_CYCLES+1)+1, which is cycle 5 for WAIT_CYCLES=1.
  - The request is occupied for 2*WAIT_CYCLES+4 cycles.
- Input changes after acceptance are ignored; the latched copy is used.
- Reset mid-operation: immediate return to IDLE, strobes go inactive in the same instant, and the partial read data is discarded (read_data=0).
- Write strobe timing: the outputs (sram_we_n, sram_dq_oe, sram_dq_out, sram_addr) are registered, so they carry no combinational glitch on sram_we_n.

Decomposition:
- Shared package (mem_pkg): state enum {IDLE, LOW, HIGH, DONE} and localparam DATA_MEM_BASE=1024. The same base constant is reused by the testbench SRAM model.
- No sub-module. FSM, counter and output registers live in one module.
- A behavioural sram_model (bench only) provides sram_dq_in from a 2^SRAM_AW x 16 array.

Test Plan:
- Reset with no request → ready=1, sram_we_n=1, sram_oe_n=1, sram_dq_oe=0, read_data=0.
- wr_en=1, address=1024, write_data=32'hDEADBEEF (WAIT_CYCLES=1) → cycles 1-2: sram_addr=0, dq=16'hBEEF, we_n=0; cycles 3-4: sram_addr=1, dq=16'hDEAD; ready=0 in cycles 0-4 and ready=1 in cycle 5.
- rd_en=1, address=1024 after the write → read_data=32'hDEADBEEF when ready=1 in cycle 5; sram_oe_n=0 in cycles 1-4.
- address=1028 write of 32'h12345678 then read → sram_addr 2/3 carry 5678/1234; read returns 32'h12345678; word at 1024 is unchanged.
- rd_en=wr_en=1, address=1032, data=32'hA5A5_0F0F → SRAM addresses 4/5 are written and read_data is unchanged. Also change address mid-request → the latched address is still used.
- Reset pulse during HIGH of a write → sram_we_n=1 and state=IDLE at once. With the request removed, ready=1. A request held through reset restarts from LOW and completes in the normal 6 cycles.
